// File: rtl/syn_fgyrus_fft_cache_hst_arb.sv
// rtl/syn_fgyrus_fft_cache_hst_arb.sv - two-requester round-robin arbiter for the FFT cache host port with ping-pong swap drain
//
// Ports:
//   clk_ir, rst_sync_l                 clock, synchronous active-low reset
//   lb_*  (req/wr/addr/wdata in,       local-bus requester: gnt accepts the held request,
//          gnt/rd_valid/rd_data out)   rd_valid/rd_data return its reads
//   vis_* (same as lb_*)               visualiser requester
//   hst_rd_en/wr_en/addr/wr_data out   registered cache host access, one cycle after acceptance
//   hst_rd_valid/rd_data in            cache host read return, P_RDELAY cycles after hst_rd_en
//   swap_req in, swap_ack out          ping-pong swap handshake with the FFT FSM
//   fft_done out                       one-cycle swap pulse to the cache
//   err_unexp_rd out                   sticky: read data returned with no tracked read
module syn_fgyrus_fft_cache_hst_arb #(
    parameter int P_DATA_W = 32,
    parameter int P_ADDR_W = 8,
    parameter int P_RDELAY = 2
) (
    input  logic                clk_ir,
    input  logic                rst_sync_l,
    input  logic                lb_req,
    input  logic                lb_wr,
    input  logic [P_ADDR_W-1:0] lb_addr,
    input  logic [P_DATA_W-1:0] lb_wdata,
    output logic                lb_gnt,
    output logic                lb_rd_valid,
    output logic [P_DATA_W-1:0] lb_rd_data,
    input  logic                vis_req,
    input  logic                vis_wr,
    input  logic [P_ADDR_W-1:0] vis_addr,
    input  logic [P_DATA_W-1:0] vis_wdata,
    output logic                vis_gnt,
    output logic                vis_rd_valid,
    output logic [P_DATA_W-1:0] vis_rd_data,
    output logic                hst_rd_en,
    output logic                hst_wr_en,
    output logic [P_ADDR_W-1:0] hst_addr,
    output logic [P_DATA_W-1:0] hst_wr_data,
    input  logic                hst_rd_valid,
    input  logic [P_DATA_W-1:0] hst_rd_data,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                fft_done,
    output logic                err_unexp_rd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t              state;
    logic                last_vis;      // 1 = vis won the most recent grant
    logic [2:0]          rd_cnt;        // reads accepted but not yet returned
    logic                hst_src;       // source of the access on the host strobes, 1 = vis
    logic [P_RDELAY-1:0] tag_v;
    logic [P_RDELAY-1:0] tag_src;

    logic arb_open;
    logic acc;
    logic acc_wr;
    logic rd_acc;
    logic emerge_v;
    logic emerge_src;
    logic rd_dec;

    // swap_req wins over requests in IDLE so the drain starts with nothing new accepted
    assign arb_open = rst_sync_l && (state == ST_IDLE) && !swap_req;
    assign lb_gnt   = arb_open && lb_req && (!vis_req || last_vis);
    assign vis_gnt  = arb_open && vis_req && (!lb_req || !last_vis);

    assign acc    = lb_gnt || vis_gnt;
    assign acc_wr = vis_gnt ? vis_wr : lb_wr;
    assign rd_acc = acc && !acc_wr;

    assign emerge_v   = tag_v[P_RDELAY-1];
    assign emerge_src = tag_src[P_RDELAY-1];

    assign lb_rd_valid  = hst_rd_valid && emerge_v && !emerge_src;
    assign vis_rd_valid = hst_rd_valid && emerge_v && emerge_src;
    assign lb_rd_data   = hst_rd_data;
    assign vis_rd_data  = hst_rd_data;

    assign swap_ack = (state == ST_SWAP);
    assign fft_done = (state == ST_SWAP);

    // a stray return with nothing counted must not wrap the counter and stall the drain
    assign rd_dec = hst_rd_valid && (rd_cnt != 3'd0);

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            state        <= ST_IDLE;
            last_vis     <= 1'b1;
            rd_cnt       <= 3'd0;
            hst_src      <= 1'b0;
            hst_rd_en    <= 1'b0;
            hst_wr_en    <= 1'b0;
            hst_addr     <= '0;
            hst_wr_data  <= '0;
            tag_v        <= '0;
            tag_src      <= '0;
            err_unexp_rd <= 1'b0;
        end else begin
            hst_rd_en <= rd_acc;
            hst_wr_en <= acc && acc_wr;
            if (acc) begin
                hst_addr    <= vis_gnt ? vis_addr : lb_addr;
                hst_wr_data <= vis_gnt ? vis_wdata : lb_wdata;
                hst_src     <= vis_gnt;
                last_vis    <= vis_gnt;
            end

            // tags enter with the read strobe so they surface with the cache return
            tag_v[0]   <= hst_rd_en;
            tag_src[0] <= hst_src;
            for (int i = 1; i < P_RDELAY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_src[i] <= tag_src[i-1];
            end

            case ({rd_acc, rd_dec})
                2'b10:   rd_cnt <= rd_cnt + 3'd1;
                2'b01:   rd_cnt <= rd_cnt - 3'd1;
                default: rd_cnt <= rd_cnt;
            endcase

            if (hst_rd_valid && !emerge_v) begin
                err_unexp_rd <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (swap_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // a write strobe still on the bus must land in the old buffer
                    if ((rd_cnt == 3'd0) && !hst_rd_en && !hst_wr_en) begin
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syn_fgyrus_fft_cache_hst_arb.sv
// tb/tb_syn_fgyrus_fft_cache_hst_arb.sv - randomized bench for syn_fgyrus_fft_cache_hst_arb against a transaction-level model
module tb_syn_fgyrus_fft_cache_hst_arb;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst_sync_l = 1'b0;
    logic          lb_req = 1'b0, lb_wr = 1'b0;
    logic [AW-1:0] lb_addr = '0;
    logic [DW-1:0] lb_wdata = '0;
    logic          lb_gnt, lb_rd_valid;
    logic [DW-1:0] lb_rd_data;
    logic          vis_req = 1'b0, vis_wr = 1'b0;
    logic [AW-1:0] vis_addr = '0;
    logic [DW-1:0] vis_wdata = '0;
    logic          vis_gnt, vis_rd_valid;
    logic [DW-1:0] vis_rd_data;
    logic          hst_rd_en, hst_wr_en;
    logic [AW-1:0] hst_addr;
    logic [DW-1:0] hst_wr_data;
    logic          hst_rd_valid = 1'b0;
    logic [DW-1:0] hst_rd_data = '0;
    logic          swap_req = 1'b0;
    logic          swap_ack, fft_done, err_unexp_rd;

    always #5 clk = ~clk;

    syn_fgyrus_fft_cache_hst_arb #(.P_DATA_W(DW), .P_ADDR_W(AW), .P_RDELAY(RD)) dut (
        .clk_ir(clk), .rst_sync_l(rst_sync_l),
        .lb_req(lb_req), .lb_wr(lb_wr), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .lb_gnt(lb_gnt), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
        .vis_req(vis_req), .vis_wr(vis_wr), .vis_addr(vis_addr), .vis_wdata(vis_wdata),
        .vis_gnt(vis_gnt), .vis_rd_valid(vis_rd_valid), .vis_rd_data(vis_rd_data),
        .hst_rd_en(hst_rd_en), .hst_wr_en(hst_wr_en), .hst_addr(hst_addr), .hst_wr_data(hst_wr_data),
        .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .fft_done(fft_done), .err_unexp_rd(err_unexp_rd)
    );

    // cache return scheduled by the bench's own cache model
    typedef struct {
        int          due;
        bit          src;
        bit          tracked;
        logic [DW-1:0] data;
    } resp_t;

    resp_t cq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // transaction-level model state
    int            ph = 0;          // 0 idle, 1 draining, 2 swapping
    bit            m_last_vis = 1'b1;
    int            m_cnt = 0;
    bit            m_err = 1'b0;
    bit            cur_v = 1'b0, cur_wr = 1'b0, cur_src = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    bit            drop_lb = 1'b0, drop_vis = 1'b0, drop_swap = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input int p_req, input bit rst_now, input bit allow_swap, input bit force_rv);
        resp_t r;
        bit    resp_now;
        bit    open, any, win_vis, eg_lb, eg_vis;
        int    nph;
        resp_t nr;

        @(posedge clk);
        #1;
        cyc++;
        if (drop_lb)   begin lb_req   = 1'b0; drop_lb   = 1'b0; end
        if (drop_vis)  begin vis_req  = 1'b0; drop_vis  = 1'b0; end
        if (drop_swap) begin swap_req = 1'b0; drop_swap = 1'b0; end
        rst_sync_l = !rst_now;
        if (!lb_req && int'($urandom_range(99)) < p_req) begin
            lb_req = 1'b1; lb_wr = 1'($urandom); lb_addr = AW'($urandom); lb_wdata = DW'($urandom);
        end
        if (!vis_req && int'($urandom_range(99)) < p_req) begin
            vis_req = 1'b1; vis_wr = 1'($urandom); vis_addr = AW'($urandom); vis_wdata = DW'($urandom);
        end
        if (allow_swap && ph == 0 && !swap_req && $urandom_range(29) == 0) swap_req = 1'b1;

        r.due = 0; r.src = 1'b0; r.tracked = 1'b0; r.data = '0;
        resp_now = 1'b0;
        if (cq.size() > 0 && cq[0].due == cyc) begin
            r = cq.pop_front();
            resp_now = 1'b1;
        end
        hst_rd_valid = resp_now || force_rv;
        hst_rd_data  = resp_now ? r.data : DW'($urandom);

        #4;
        // round robin: on a tie the requester that did not win last time goes
        open    = !rst_now && ph == 0 && !swap_req;
        any     = lb_req || vis_req;
        win_vis = (lb_req && vis_req) ? !m_last_vis : vis_req;
        eg_lb   = open && any && !win_vis;
        eg_vis  = open && any && win_vis;

        chk("lb_gnt", lb_gnt, eg_lb);
        chk("vis_gnt", vis_gnt, eg_vis);
        chk("hst_rd_en", hst_rd_en, cur_v && !cur_wr);
        chk("hst_wr_en", hst_wr_en, cur_v && cur_wr);
        if (cur_v) chk("hst_addr", hst_addr, cur_addr);
        if (cur_v && cur_wr) chk("hst_wr_data", hst_wr_data, cur_wdata);
        chk("lb_rd_valid", lb_rd_valid, resp_now && r.tracked && !r.src);
        chk("vis_rd_valid", vis_rd_valid, resp_now && r.tracked && r.src);
        if (resp_now && r.tracked) begin
            if (r.src) chk("vis_rd_data", vis_rd_data, r.data);
            else       chk("lb_rd_data", lb_rd_data, r.data);
        end
        chk("swap_ack", swap_ack, ph == 2);
        chk("fft_done", fft_done, ph == 2);
        chk("err_unexp_rd", err_unexp_rd, m_err);

        // the cache sees this cycle's read strobe and answers RD cycles later
        if (cur_v && !cur_wr) begin
            nr.due = cyc + RD; nr.src = cur_src; nr.tracked = 1'b1; nr.data = DW'($urandom);
            cq.push_back(nr);
        end

        if (rst_now) begin
            ph = 0; m_last_vis = 1'b1; m_cnt = 0; m_err = 1'b0;
            cur_v = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0;
            foreach (cq[i]) cq[i].tracked = 1'b0;
        end else begin
            nph = ph;
            if (ph == 0 && swap_req) nph = 1;
            else if (ph == 1 && m_cnt == 0 && !cur_v) nph = 2;
            else if (ph == 2) begin nph = 0; drop_swap = 1'b1; end
            ph = nph;

            if (hst_rd_valid) begin
                if (!(resp_now && r.tracked)) m_err = 1'b1;
                if (m_cnt > 0) m_cnt--;
            end

            cur_v = eg_lb || eg_vis;
            if (eg_lb) begin
                cur_wr = lb_wr; cur_addr = lb_addr; cur_wdata = lb_wdata; cur_src = 1'b0;
                m_last_vis = 1'b0; drop_lb = 1'b1;
            end else if (eg_vis) begin
                cur_wr = vis_wr; cur_addr = vis_addr; cur_wdata = vis_wdata; cur_src = 1'b1;
                m_last_vis = 1'b1; drop_vis = 1'b1;
            end
            if (cur_v && !cur_wr) m_cnt++;
        end
    endtask

    initial begin
        repeat (2) step(0, 1'b1, 1'b0, 1'b0);

        // continuous contention: grants must alternate lb first
        repeat (30) step(100, 1'b0, 1'b0, 1'b0);

        // mixed traffic with swaps
        repeat (800) step(40, 1'b0, 1'b1, 1'b0);

        // heavy traffic with occasional mid-flight resets
        for (int i = 0; i < 400; i++) step(70, (i % 97) == 50, 1'b1, 1'b0);

        // let holds, swaps and returns settle
        repeat (12) step(0, 1'b0, 1'b0, 1'b0);

        // reset with nothing pending, then every output must be zero
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        chk("hst_addr_rst", hst_addr, '0);
        chk("hst_wr_data_rst", hst_wr_data, '0);

        // stray read return with no tracked read sets a sticky error
        step(0, 1'b0, 1'b0, 1'b1);
        repeat (4) step(0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", err_unexp_rd, 1'b1);

        // one reset cycle clears it
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        chk("err_after_rst", err_unexp_rd, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
